ps2_frame_receiver: RTL

Parametrised PS/2 device-to-host receiver that succeeds the single-byte PS/2 controller. It adds input glitch filtering, full 11-bit frame checking (start, 8 data, odd parity, stop), an inactivity timeout that aborts partial frames, and a show-ahead receive FIFO with a valid/ready handshake. It sits between the PS/2 pins and the keyboard-decode logic, and the downstream decoder may stall without losing scancodes.

---
 rtl/ps2_frame_receiver.sv | 254 +++++++++++++++++++++++++
 1 files changed

// File: rtl/ps2_frame_receiver.sv
// PS/2 device-to-host frame receiver: glitch-filtered clock, 11-bit frame check, inactivity timeout, show-ahead FIFO.
// Optional odd-parity enforcement is built only when PS2_PARITY_CHECK_EN is defined.
//
// state  | meaning
// IDLE   | waiting for a start bit (falling edge with data low)
// DATA   | shifting in 8 data bits, LSB first
// PARITY | next falling edge captures the parity bit
// STOP   | next falling edge evaluates the frame, then back to IDLE
module ps2_frame_receiver #(
   parameter int FILTER_LEN     = 4,
   parameter int TIMEOUT_CYCLES = 20000,
   parameter int FIFO_DEPTH     = 4
) (
   input  logic                               clk,
   input  logic                               rst,
   input  logic                               ps2_clk,
   input  logic                               ps2_data,
   output logic [7:0]                         rx_data,
   output logic                               rx_valid,
   input  logic                               rx_ready,
   output logic [$clog2(FIFO_DEPTH+1)-1:0]    rx_level,
   output logic                               rx_parity_err,
   output logic                               rx_frame_err,
   output logic                               rx_overflow,
   output logic                               rx_timeout
);

   localparam int FCW = $clog2(FILTER_LEN + 1);
   localparam int TCW = $clog2(TIMEOUT_CYCLES + 1);
   localparam int PW  = $clog2(FIFO_DEPTH);
   localparam int LW  = $clog2(FIFO_DEPTH + 1);

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      DATA   = 2'd1,
      PARITY = 2'd2,
      STOP   = 2'd3
   } state_t;

   state_t           state;
   state_t           state_nx;

   logic             clk_meta;
   logic             clk_sync;
   logic             data_meta;
   logic             data_sync;
   logic [FCW-1:0]   filt_cnt;
   logic             clk_filt;
   logic             clk_filt_d;
   logic             fall;

   logic [2:0]       bit_cnt;
   logic [7:0]       shreg;
   logic [TCW-1:0]   tcnt;
   logic             timeout_hit;

   logic             bit_clr;
   logic             shift_en;
   logic             push;
   logic             pop;
   logic             full;
   logic             frame_err_nx;
   logic             overflow_nx;
   logic             timeout_nx;

   logic [7:0]       mem [FIFO_DEPTH];
   logic [PW-1:0]    wr_ptr;
   logic [PW-1:0]    rd_ptr;
   logic [LW-1:0]    count;

   // Input synchronisers idle high, matching an undriven PS/2 bus.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         clk_meta  <= 1'b1;
         clk_sync  <= 1'b1;
         data_meta <= 1'b1;
         data_sync <= 1'b1;
      end else begin
         clk_meta  <= ps2_clk;
         clk_sync  <= clk_meta;
         data_meta <= ps2_data;
         data_sync <= data_meta;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         filt_cnt   <= '0;
         clk_filt   <= 1'b1;
         clk_filt_d <= 1'b1;
         fall       <= 1'b0;
      end else begin
         clk_filt_d <= clk_filt;
         fall       <= clk_filt_d & ~clk_filt;
         if (clk_sync == clk_filt) begin
            filt_cnt <= '0;
         end else if (filt_cnt == FCW'(FILTER_LEN - 1)) begin
            clk_filt <= clk_sync;
            filt_cnt <= '0;
         end else begin
            filt_cnt <= filt_cnt + FCW'(1);
         end
      end
   end

   // A falling edge in the same cycle as the terminal count wins: the frame is still alive.
   assign timeout_hit = (state != IDLE) && !fall && (tcnt == TCW'(TIMEOUT_CYCLES - 1));

   assign full = (count == LW'(FIFO_DEPTH));
   assign pop  = rx_valid & rx_ready;

`ifdef PS2_PARITY_CHECK_EN
   logic par_bit;
   logic par_en;
   logic parity_bad;
   logic parity_err_nx;

   assign parity_bad = ~(^{shreg, par_bit});

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         par_bit       <= 1'b0;
         rx_parity_err <= 1'b0;
      end else begin
         if (par_en) begin
            par_bit <= data_sync;
         end
         rx_parity_err <= parity_err_nx;
      end
   end
`else
   assign rx_parity_err = 1'b0;
`endif

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state <= IDLE;
      end else begin
         state <= state_nx;
      end
   end

   always_comb begin
      state_nx      = state;
      bit_clr       = 1'b0;
      shift_en      = 1'b0;
      push          = 1'b0;
      frame_err_nx  = 1'b0;
      overflow_nx   = 1'b0;
      timeout_nx    = 1'b0;
`ifdef PS2_PARITY_CHECK_EN
      par_en        = 1'b0;
      parity_err_nx = 1'b0;
`endif
      if (timeout_hit) begin
         state_nx   = IDLE;
         timeout_nx = 1'b1;
      end else if (fall) begin
         case (state)
            IDLE: begin
               if (!data_sync) begin
                  state_nx = DATA;
                  bit_clr  = 1'b1;
               end
            end
            DATA: begin
               shift_en = 1'b1;
               if (bit_cnt == 3'd7) begin
                  state_nx = PARITY;
               end
            end
            PARITY: begin
`ifdef PS2_PARITY_CHECK_EN
               par_en   = 1'b1;
`endif
               state_nx = STOP;
            end
            STOP: begin
               state_nx = IDLE;
               if (!data_sync) begin
                  frame_err_nx = 1'b1;
`ifdef PS2_PARITY_CHECK_EN
               end else if (parity_bad) begin
                  parity_err_nx = 1'b1;
`endif
               end else if (full && !pop) begin
                  overflow_nx = 1'b1;
               end else begin
                  push = 1'b1;
               end
            end
            default: state_nx = IDLE;
         endcase
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         bit_cnt      <= '0;
         shreg        <= '0;
         tcnt         <= '0;
         rx_frame_err <= 1'b0;
         rx_overflow  <= 1'b0;
         rx_timeout   <= 1'b0;
      end else begin
         if (bit_clr) begin
            bit_cnt <= '0;
         end else if (shift_en) begin
            bit_cnt <= bit_cnt + 3'd1;
            shreg   <= {data_sync, shreg[7:1]};
         end
         if (fall || timeout_hit || state == IDLE) begin
            tcnt <= '0;
         end else begin
            tcnt <= tcnt + TCW'(1);
         end
         rx_frame_err <= frame_err_nx;
         rx_overflow  <= overflow_nx;
         rx_timeout   <= timeout_nx;
      end
   end

   // Storage needs no reset; the head is masked while the FIFO is empty.
   always_ff @(posedge clk) begin
      if (push) begin
         mem[wr_ptr] <= shreg;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (push) begin
            wr_ptr <= wr_ptr + PW'(1);
         end
         if (pop) begin
            rd_ptr <= rd_ptr + PW'(1);
         end
         case ({push, pop})
            2'b10:   count <= count + LW'(1);
            2'b01:   count <= count - LW'(1);
            default: count <= count;
         endcase
      end
   end

   assign rx_valid = (count != '0);
   assign rx_level = count;
   assign rx_data  = rx_valid ? mem[rd_ptr] : 8'h00;

endmodule
